// File: rtl/frame_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : frame_param_pkg
//  Purpose  : Shared types and constants for the frame parameter loader:
//             FSM state encoding, field index map of the parameter block and
//             default parameter values.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package frame_param_pkg;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_READ   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Position of each parameter word within the committed field bus
  localparam int FLD_X_POINTS   = 0;
  localparam int FLD_X_BLOCKS   = 1;
  localparam int FLD_Y_POINTS   = 2;
  localparam int FLD_CYC_PER_PT = 3;
  localparam int FLD_DA_DLY     = 4;
  localparam int FLD_ACQ_DLY    = 5;
  localparam int FLD_CCD_DLY    = 6;
  localparam int FLD_SYS_STATE  = 7;

  // Default configuration
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ADDR_W      = 13;
  localparam int DEF_NUM_FIELDS  = 8;
  localparam int DEF_BASE_ADDR   = 0;
  localparam int DEF_ADDR_STRIDE = 2;
  localparam int DEF_RD_LATENCY  = 1;
  localparam int DEF_WAIT_CYCLES = 1;

endpackage
`default_nettype wire

// File: rtl/frame_param_loader_rdy_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : rdy_edge_sync
//  Purpose  : Two-flop synchroniser for the (possibly asynchronous) data_rdy
//             level, followed by a delay flop and a rising-edge detector.
//  Ports    : clk      - system clock
//             rst_n    - asynchronous active-low reset
//             data_rdy - raw ready level from the PC side
//             start    - one-cycle pulse on a synchronised rising edge
//  Revision : 1.0 - initial release
// ============================================================================
module rdy_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic data_rdy,
  output logic start
);

  logic d0;
  logic d1;
  logic d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0 <= 1'b0;
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d0 <= data_rdy;
      d1 <= d0;
      d2 <= d1;
    end
  end

  assign start = d1 & ~d2;

endmodule
`default_nettype wire

// File: rtl/frame_param_loader.sv
`default_nettype none
// ============================================================================
//  Module   : frame_param_loader
//  Purpose  : On a rising edge of data_rdy, reads NUM_FIELDS parameter words
//             from BRAM with a fully pipelined read, collects them in shadow
//             registers and commits them atomically to the fields bus,
//             followed by a one-cycle frame_done pulse.
//  Options  : `define FRAME_PARAM_CHECKSUM_EN to read one extra XOR checksum
//             word after the fields; a mismatching frame is not committed
//             and pulses csum_err instead of frame_done.
//  Ports    : clk, rst_n         - clock, asynchronous active-low reset
//             data_rdy           - PC finished writing BRAM (level, async)
//             abort              - drop the frame in progress
//             rd_en, addr        - BRAM read port request
//             rd_data            - BRAM read data (RD_LATENCY clocks later)
//             fields             - committed fields, field i at [i*DATA_W +: DATA_W]
//             frame_done         - pulse when fields are committed
//             frame_valid        - sticky: a frame was committed since reset
//             busy               - FSM not idle
//             overrun            - pulse when a start arrives while busy
//             csum_err           - (checksum build only) checksum mismatch pulse
//  Revision : 1.0 - initial release
// ============================================================================
module frame_param_loader
  import frame_param_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_FIELDS  = DEF_NUM_FIELDS,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int ADDR_STRIDE = DEF_ADDR_STRIDE,
  parameter int RD_LATENCY  = DEF_RD_LATENCY,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         data_rdy,
  input  logic                         abort,
  output logic                         rd_en,
  output logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            rd_data,
  output logic [NUM_FIELDS*DATA_W-1:0] fields,
  output logic                         frame_done,
  output logic                         frame_valid,
  output logic                         busy,
`ifdef FRAME_PARAM_CHECKSUM_EN
  output logic                         csum_err,
`endif
  output logic                         overrun
);

  // The checksum word, when present, is simply one more word in the burst.
`ifdef FRAME_PARAM_CHECKSUM_EN
  localparam int NUM_WORDS = NUM_FIELDS + 1;
`else
  localparam int NUM_WORDS = NUM_FIELDS;
`endif
  localparam int READ_LEN = NUM_WORDS + RD_LATENCY;
  localparam int CNT_W    = $clog2(READ_LEN + 1);
  localparam int IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_t              state;
  state_t              state_nxt;
  logic                start;
  logic [7:0]          wait_cnt;
  logic [CNT_W-1:0]    rd_cnt;
  logic                issue;
  logic                last_read;
  logic [ADDR_W-1:0]   issue_addr;
  logic [ADDR_W-1:0]   addr_hold;
  logic                csum_ok;
  logic [DATA_W-1:0]   shadow   [NUM_WORDS];
  logic                pipe_vld [RD_LATENCY];
  logic [IDX_W-1:0]    pipe_idx [RD_LATENCY];

  rdy_edge_sync u_rdy_edge_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_rdy (data_rdy),
    .start    (start)
  );

  // Issue cycles are the first NUM_WORDS cycles of READ; the remaining
  // RD_LATENCY cycles only drain the capture pipe.
  assign issue      = (state == ST_READ) && (rd_cnt < CNT_W'(NUM_WORDS));
  assign last_read  = (rd_cnt == CNT_W'(READ_LEN - 1));
  // ADDR_W-wide arithmetic gives the modulo 2^ADDR_W wrap for free.
  assign issue_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_cnt) * ADDR_W'(ADDR_STRIDE);

`ifdef FRAME_PARAM_CHECKSUM_EN
  logic [DATA_W-1:0] csum_calc;

  always_comb begin
    csum_calc = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      csum_calc = csum_calc ^ shadow[i];
    end
  end

  assign csum_ok = (csum_calc == shadow[NUM_FIELDS]);
`else
  assign csum_ok = 1'b1;
`endif

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (WAIT_CYCLES == 0) ? ST_READ : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 8'd1) begin
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (last_read) begin
          state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    // Abort overrides every transition, including the one into COMMIT.
    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
    end
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    busy  = (state != ST_IDLE);
    rd_en = issue;
    addr  = issue ? issue_addr : addr_hold;
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      rd_cnt      <= '0;
      addr_hold   <= '0;
      fields      <= '0;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
`ifdef FRAME_PARAM_CHECKSUM_EN
      csum_err    <= 1'b0;
`endif
      for (int i = 0; i < NUM_WORDS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      overrun    <= start && busy;
`ifdef FRAME_PARAM_CHECKSUM_EN
      csum_err   <= 1'b0;
`endif

      case (state)
        ST_IDLE: begin
          if (start) begin
            rd_cnt   <= '0;
            wait_cnt <= 8'(WAIT_CYCLES);
          end
        end
        ST_WAIT: wait_cnt <= wait_cnt - 8'd1;
        ST_READ: rd_cnt   <= rd_cnt + CNT_W'(1);
        default: ;
      endcase

      if (issue) begin
        addr_hold <= issue_addr;
      end

      if ((state == ST_READ) && pipe_vld[RD_LATENCY-1]) begin
        shadow[pipe_idx[RD_LATENCY-1]] <= rd_data;
      end

      if ((state == ST_COMMIT) && !abort) begin
        if (csum_ok) begin
          for (int i = 0; i < NUM_FIELDS; i++) begin
            fields[i*DATA_W +: DATA_W] <= shadow[i];
          end
          frame_done  <= 1'b1;
          frame_valid <= 1'b1;
        end else begin
`ifdef FRAME_PARAM_CHECKSUM_EN
          csum_err <= 1'b1;
`endif
        end
      end
    end
  end

  // Capture pipe: stage RD_LATENCY-1 is valid in the cycle whose closing edge
  // samples rd_data for that issue. Flushed outside READ so an aborted frame
  // leaves nothing in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_idx[i] <= '0;
      end
    end else if (state != ST_READ) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
      end
    end else begin
      pipe_vld[0] <= issue;
      pipe_idx[0] <= IDX_W'(rd_cnt);
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_param_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_param_loader
//  Purpose  : Directed self-checking bench for frame_param_loader. Instance A
//             uses the default configuration, instance B uses a wrapping
//             address window with RD_LATENCY=3, WAIT_CYCLES=0, NUM_FIELDS=4.
//             Each instance has a behavioural BRAM with matching latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_param_loader;

`ifdef FRAME_PARAM_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NW_A  = 8 + CS;
  localparam int LAT_A = 14 + CS;
  localparam int NW_B  = 4 + CS;
  localparam int LAT_B = 11 + CS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  logic          data_rdy_a = 1'b0;
  logic          abort_a = 1'b0;
  logic          rd_en_a;
  logic [12:0]   addr_a;
  logic [15:0]   rd_data_a;
  logic [127:0]  fields_a;
  logic          frame_done_a;
  logic          frame_valid_a;
  logic          busy_a;
  logic          overrun_a;

  logic          data_rdy_b = 1'b0;
  logic          abort_b = 1'b0;
  logic          rd_en_b;
  logic [12:0]   addr_b;
  logic [15:0]   rd_data_b;
  logic [63:0]   fields_b;
  logic          frame_done_b;
  logic          frame_valid_b;
  logic          busy_b;
  logic          overrun_b;

`ifdef FRAME_PARAM_CHECKSUM_EN
  logic          csum_err_a;
  logic          csum_err_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_param_loader u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_rdy    (data_rdy_a),
    .abort       (abort_a),
    .rd_en       (rd_en_a),
    .addr        (addr_a),
    .rd_data     (rd_data_a),
    .fields      (fields_a),
    .frame_done  (frame_done_a),
    .frame_valid (frame_valid_a),
    .busy        (busy_a),
`ifdef FRAME_PARAM_CHECKSUM_EN
    .csum_err    (csum_err_a),
`endif
    .overrun     (overrun_a)
  );

  frame_param_loader #(
    .DATA_W      (16),
    .ADDR_W      (13),
    .NUM_FIELDS  (4),
    .BASE_ADDR   ('h1FFC),
    .ADDR_STRIDE (2),
    .RD_LATENCY  (3),
    .WAIT_CYCLES (0)
  ) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_rdy    (data_rdy_b),
    .abort       (abort_b),
    .rd_en       (rd_en_b),
    .addr        (addr_b),
    .rd_data     (rd_data_b),
    .fields      (fields_b),
    .frame_done  (frame_done_b),
    .frame_valid (frame_valid_b),
    .busy        (busy_b),
`ifdef FRAME_PARAM_CHECKSUM_EN
    .csum_err    (csum_err_b),
`endif
    .overrun     (overrun_b)
  );

  // Behavioural BRAMs: A has one clock of latency, B has three.
  logic [15:0] mem_a [8192];
  logic [15:0] mem_b [8192];
  logic [15:0] pa;
  logic [15:0] pb0, pb1, pb2;

  always @(posedge clk) begin
    pa  <= mem_a[addr_a];
    pb0 <= mem_b[addr_b];
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign rd_data_a = pa;
  assign rd_data_b = pb2;

  logic [12:0] iss_addr [16];
  logic [12:0] exp_b_addr [5];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Raise data_rdy and follow the frame until frame_done (bounded). Edges are
  // counted starting with the edge that first samples data_rdy high.
  task automatic run_frame(input bit sel, input int max_edges, output int edges,
                           output int n_iss, output int first_iss,
                           output int last_iss, output bit done_seen);
    edges = 0; n_iss = 0; first_iss = 0; last_iss = 0; done_seen = 1'b0;
    if (sel) data_rdy_b = 1'b1;
    else     data_rdy_a = 1'b1;
    while (!done_seen && edges < max_edges) begin
      tick();
      edges++;
      if (sel ? rd_en_b : rd_en_a) begin
        if (n_iss < 16) iss_addr[n_iss] = sel ? addr_b : addr_a;
        if (n_iss == 0) first_iss = edges;
        last_iss = edges;
        n_iss++;
      end
      if (sel ? frame_done_b : frame_done_a) done_seen = 1'b1;
    end
  endtask

  initial begin
    int  edges, n_iss, f_iss, l_iss;
    bit  done;
    int  n_ov, n_fd, n_act;

    for (int i = 0; i < 8192; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end
    for (int i = 0; i < 8; i++) mem_a[2*i] = 16'h0100 + 16'(i);
    mem_b['h1FFC] = 16'hA001;
    mem_b['h1FFE] = 16'hA002;
    mem_b['h0000] = 16'hA003;
    mem_b['h0002] = 16'hA004;
    mem_b['h0004] = 16'h0004;   // XOR of the four B words
    exp_b_addr[0] = 13'h1FFC;
    exp_b_addr[1] = 13'h1FFE;
    exp_b_addr[2] = 13'h0000;
    exp_b_addr[3] = 13'h0002;
    exp_b_addr[4] = 13'h0004;

    // ---------------- reset state
    repeat (3) tick();
    check("rst_busy_a",        64'(busy_a), 64'd0);
    check("rst_rd_en_a",       64'(rd_en_a), 64'd0);
    check("rst_addr_a",        64'(addr_a), 64'd0);
    check("rst_frame_done_a",  64'(frame_done_a), 64'd0);
    check("rst_frame_valid_a", 64'(frame_valid_a), 64'd0);
    check("rst_overrun_a",     64'(overrun_a), 64'd0);
    check("rst_fields_lo_a",   fields_a[63:0], 64'd0);
    check("rst_busy_b",        64'(busy_b), 64'd0);
`ifdef FRAME_PARAM_CHECKSUM_EN
    check("rst_csum_err_a",    64'(csum_err_a), 64'd0);
`endif
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_busy_a", 64'(busy_a), 64'd0);

    // ---------------- test 1: default frame
    run_frame(1'b0, 40, edges, n_iss, f_iss, l_iss, done);
    check("t1_done_seen", 64'(done), 64'd1);
    check("t1_latency",   64'(edges), 64'(LAT_A));
    check("t1_iss_cnt",   64'(n_iss), 64'(NW_A));
    check("t1_iss_span",  64'(l_iss - f_iss + 1), 64'(NW_A));
    for (int i = 0; i < NW_A; i++) check($sformatf("t1_addr%0d", i), 64'(iss_addr[i]), 64'(2*i));
    for (int i = 0; i < 8; i++) check($sformatf("t1_field%0d", i), 64'(fields_a[i*16 +: 16]), 64'(16'h0100 + i));
    check("t1_valid", 64'(frame_valid_a), 64'd1);
    tick();
    check("t1_done_pulse", 64'(frame_done_a), 64'd0);
    check("t1_busy_after", 64'(busy_a), 64'd0);
    data_rdy_a = 1'b0;
    repeat (5) tick();

    // ---------------- test 2: wrapping address, latency 3, no wait
    run_frame(1'b1, 40, edges, n_iss, f_iss, l_iss, done);
    check("t2_done_seen", 64'(done), 64'd1);
    check("t2_latency",   64'(edges), 64'(LAT_B));
    check("t2_iss_cnt",   64'(n_iss), 64'(NW_B));
    check("t2_iss_span",  64'(l_iss - f_iss + 1), 64'(NW_B));
    for (int i = 0; i < NW_B; i++) check($sformatf("t2_addr%0d", i), 64'(iss_addr[i]), 64'(exp_b_addr[i]));
    check("t2_field0", 64'(fields_b[15:0]),  64'hA001);
    check("t2_field1", 64'(fields_b[31:16]), 64'hA002);
    check("t2_field2", 64'(fields_b[47:32]), 64'hA003);
    check("t2_field3", 64'(fields_b[63:48]), 64'hA004);
    check("t2_valid",  64'(frame_valid_b), 64'd1);
    data_rdy_b = 1'b0;
    repeat (5) tick();

    // ---------------- test 3: second rising edge during READ
    for (int i = 0; i < 8; i++) mem_a[2*i] = 16'h0300 + 16'(i);
    n_ov = 0; n_fd = 0;
    data_rdy_a = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 3) data_rdy_a = 1'b0;
      if (c == 5) data_rdy_a = 1'b1;
      if (overrun_a) n_ov++;
      if (frame_done_a) n_fd++;
    end
    check("t3_overrun_cnt", 64'(n_ov), 64'd1);
    check("t3_done_cnt",    64'(n_fd), 64'd1);
    for (int i = 0; i < 8; i++) check($sformatf("t3_field%0d", i), 64'(fields_a[i*16 +: 16]), 64'(16'h0300 + i));
    data_rdy_a = 1'b0;
    repeat (5) tick();

    // ---------------- test 4: abort during READ
    for (int i = 0; i < 8; i++) mem_a[2*i] = 16'h0400 + 16'(i);
    data_rdy_a = 1'b1;
    repeat (5) tick();
    check("t4_busy_before", 64'(busy_a), 64'd1);
    abort_a = 1'b1;
    tick();
    check("t4_busy_abort", 64'(busy_a), 64'd0);
    abort_a = 1'b0;
    n_fd = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (frame_done_a) n_fd++;
    end
    check("t4_done_cnt", 64'(n_fd), 64'd0);
    for (int i = 0; i < 8; i++) check($sformatf("t4_field%0d", i), 64'(fields_a[i*16 +: 16]), 64'(16'h0300 + i));
    check("t4_valid", 64'(frame_valid_a), 64'd1);
    data_rdy_a = 1'b0;
    repeat (5) tick();

    // ---------------- test 5: asynchronous reset mid-READ
    for (int i = 0; i < 8; i++) mem_a[2*i] = 16'h0500 + 16'(i);
    data_rdy_a = 1'b1;
    repeat (5) tick();
    check("t5_rd_en_before", 64'(rd_en_a), 64'd1);
    #2;
    rst_n = 1'b0;
    data_rdy_a = 1'b0;
    #1;
    check("t5_busy",        64'(busy_a), 64'd0);
    check("t5_rd_en",       64'(rd_en_a), 64'd0);
    check("t5_addr",        64'(addr_a), 64'd0);
    check("t5_frame_valid", 64'(frame_valid_a), 64'd0);
    check("t5_fields_lo",   fields_a[63:0], 64'd0);
    check("t5_fields_hi",   fields_a[127:64], 64'd0);
    check("t5_valid_b",     64'(frame_valid_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_act = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (busy_a || rd_en_a || frame_done_a) n_act++;
    end
    check("t5_quiet", 64'(n_act), 64'd0);
    run_frame(1'b0, 40, edges, n_iss, f_iss, l_iss, done);
    check("t5_done_seen", 64'(done), 64'd1);
    check("t5_latency",   64'(edges), 64'(LAT_A));
    for (int i = 0; i < 8; i++) check($sformatf("t5_field%0d", i), 64'(fields_a[i*16 +: 16]), 64'(16'h0500 + i));
    data_rdy_a = 1'b0;
    repeat (5) tick();

`ifdef FRAME_PARAM_CHECKSUM_EN
    // ---------------- test 6: checksum good then corrupt
    for (int i = 0; i < 8; i++) mem_a[2*i] = 16'h0600 + 16'(i);
    mem_a[16] = 16'h0000;      // XOR of 0x0600..0x0607
    run_frame(1'b0, 40, edges, n_iss, f_iss, l_iss, done);
    check("t6_done_seen", 64'(done), 64'd1);
    check("t6_latency",   64'(edges), 64'd15);
    check("t6_addr8",     64'(iss_addr[8]), 64'd16);
    for (int i = 0; i < 8; i++) check($sformatf("t6_field%0d", i), 64'(fields_a[i*16 +: 16]), 64'(16'h0600 + i));
    data_rdy_a = 1'b0;
    repeat (5) tick();

    for (int i = 0; i < 8; i++) mem_a[2*i] = 16'h0700 + 16'(i);
    mem_a[16] = 16'h0001;      // correct value would be 0x0000
    n_fd = 0; n_ov = 0;
    data_rdy_a = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (frame_done_a) n_fd++;
      if (csum_err_a) n_ov++;
    end
    check("t6_csum_err_cnt", 64'(n_ov), 64'd1);
    check("t6_bad_done_cnt", 64'(n_fd), 64'd0);
    for (int i = 0; i < 8; i++) check($sformatf("t6_kept%0d", i), 64'(fields_a[i*16 +: 16]), 64'(16'h0600 + i));
    data_rdy_a = 1'b0;
    repeat (5) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_param_loader.md
Name: frame_param_loader

Overview:
- Generalised successor of the frame header reader.
- On a rising edge of `data_rdy` (PC has finished writing BRAM), it reads `NUM_FIELDS` parameter words from BRAM, using a fully pipelined read at a configurable read latency.
- Captured words go into shadow registers. They are committed atomically to a flat output bus, followed by a one-cycle `frame_done` pulse.
- Sits between the PC-written BRAM and the scan/acquisition timing blocks: DA, ACQ and CCD delays, points per line, system state.

Parameters:
- `DATA_W`, 16, BRAM word and field width.
- `ADDR_W`, 13, BRAM address width.
- `NUM_FIELDS`, 8, number of parameter words per frame (1..32).
- `BASE_ADDR`, 0, address of field 0.
- `ADDR_STRIDE`, 2, address increment between fields.
- `RD_LATENCY`, 1, BRAM clocks from address to valid data (1..4).
- `WAIT_CYCLES`, 1, settle cycles after start before the first read (0..255).

Ports:
- `clk`, in, 1, system clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `data_rdy`, in, 1, PC has finished writing BRAM (level, may be asynchronous).
- `abort`, in, 1, synchronous abort of the frame in progress.
- `rd_en`, out, 1, BRAM read enable.
- `addr`, out, `ADDR_W`, BRAM read address.
- `rd_data`, in, `DATA_W`, BRAM read data.
- `fields`, out, `NUM_FIELDS*DATA_W`, committed fields; field i is at bits `[i*DATA_W +: DATA_W]`.
- `frame_done`, out, 1, one-cycle pulse when new fields are committed.
- `frame_valid`, out, 1, sticky flag: at least one frame has been committed since reset.
- `busy`, out, 1, high whenever the FSM is not in IDLE.
- `overrun`, out, 1, one-cycle pulse when a start is detected while busy.

Behaviour:
- Reset: one clock `clk`; reset is asynchronous, active-low on `rst_n`. All outputs, shadow registers and sync flops clear to 0. The FSM goes to IDLE. Reset mid-frame discards everything, including previously committed fields.
- Start detection:
  - `data_rdy` passes through 2-FF sync d0, d1, then delay d2.
  - `start = d1 & ~d2`.
  - The FSM leaves IDLE on the second `clk` edge after `data_rdy` is first sampled high.
- FSM states: IDLE, WAIT, READ, COMMIT.
  - IDLE: on `start`, go to WAIT (or READ if `WAIT_CYCLES=0`). Clear issue and capture indices, load the wait counter.
  - WAIT: stays exactly `WAIT_CYCLES` cycles, then goes to READ.
  - READ: lasts `NUM_FIELDS+RD_LATENCY` cycles.
    - Issue cycle k (k < `NUM_FIELDS`): `rd_en=1`, `addr=BASE_ADDR+k*ADDR_STRIDE`, truncated to `ADDR_W` (wraps modulo 2^`ADDR_W`).
    - Capture: data for issue k is sampled from `rd_data` at READ cycle k+`RD_LATENCY` into shadow[k].
    - Capture is tracked with a `RD_LATENCY`-deep valid/index shift pipe.
  - COMMIT: one cycle. `fields <= shadow`, `frame_done <= 1`, `frame_valid <= 1`, next state IDLE.
- Output timing: `frame_done` is high the cycle after COMMIT; `fields` update on the same edge. `rd_en` is 0 and `addr` holds its last value outside issue cycles.
- Latency:
  - Edges from first sampled `data_rdy` high to `frame_done` high = 2 + `WAIT_CYCLES` + `NUM_FIELDS` + `RD_LATENCY` + 2.
  - Defaults give 14.
- `start` while busy: ignored, `overrun` pulses. The frame in progress is unaffected.
- `abort`: in any non-IDLE state, returns to IDLE next edge.
  - No commit; `fields` and `frame_valid` are retained.
  - `abort` wins over a simultaneous transition to COMMIT.
- `data_rdy` falling mid-frame has no effect. A new frame requires a fresh rising edge.
- `fields` never shows partially updated data.

Optional Feature:
- Macro: `FRAME_PARAM_CHECKSUM_EN`.
- Enabled:
  - One extra word at index `NUM_FIELDS` (same stride) is read; READ lasts `NUM_FIELDS+1+RD_LATENCY` cycles.
  - At COMMIT, if the XOR of shadow[0..`NUM_FIELDS`-1] differs from the checksum word: no commit, no `frame_done`, and the extra output `csum_err` (1 bit) pulses one cycle.
- Disabled: no extra read, no `csum_err` port, always commits.

Decomposition:
- Package `frame_param_pkg`:
  - FSM state enum.
  - Field index constants: `FLD_X_POINTS=0`, `FLD_X_BLOCKS=1`, `FLD_Y_POINTS=2`, `FLD_CYC_PER_PT=3`, `FLD_DA_DLY=4`, `FLD_ACQ_DLY=5`, `FLD_CCD_DLY=6`, `FLD_SYS_STATE=7`.
  - Default parameter values.
- Sub-module `rdy_edge_sync`: 2-FF synchroniser plus rising-edge detector, outputs `start`.

Test Plan:
- Defaults, BRAM model latency 1, words 0x0100..0x0107 at addr 0,2,..,14; raise `data_rdy` → `rd_en` high 8 consecutive cycles, addr 0..14 step 2. `frame_done` rises 14 edges after `data_rdy` first sampled high. Field i = 0x0100+i; `frame_valid=1`.
- `RD_LATENCY=3`, `WAIT_CYCLES=0`, `NUM_FIELDS=4`, `BASE_ADDR=0x1FFC`, `ADDR_STRIDE=2` → addr sequence 0x1FFC, 0x1FFE, 0x0000, 0x0002. Fields match the model data; `frame_done` 2+0+4+3+2=11 edges after `data_rdy`.
- Second `data_rdy` rising edge during READ → `overrun` pulses once. Exactly one `frame_done`; fields come from the first frame only.
- Frame 1 committed with 0x0100..; frame 2 started with new data, `abort` during READ → `busy` drops next edge. No `frame_done`; fields still 0x0100.., `frame_valid=1`.
- `rst_n` low mid-READ → all outputs 0 immediately (asynchronous); after release no activity until a new `data_rdy` rising edge.
- `FRAME_PARAM_CHECKSUM_EN`: correct XOR word at addr 16 → commit after 15 edges. Corrupt checksum → `csum_err` pulse, no `frame_done`, fields unchanged.
